alu_8bit: RTL and testbench
===========================

// Module: alu_8bit
// PURPOSE
//  - Datapath ALU: bitwise logic, add/subtract and signed set-less-than on two WIDTH-bit operands.
//  - MIPS-style 4-bit control word selects the operation.
//  - Result, carry-out and zero flag are registered (1-cycle latency).
//  - Sits behind the ALU control decoder in the execute stage.
// PARAMETERS
//  - WIDTH  8  operand/result width in bits; A and B are two's complement
// PORTS
//  - clk       in   1      clock, rising edge
//  - rst_n     in   1      reset, asynchronous, active-low
//  - A         in   WIDTH  operand A (signed)
//  - B         in   WIDTH  operand B (signed)
//  - ALU_cont  in   4      [3]=Ainvert, [2]=Binvert, [1:0]=op (00 AND, 01 OR, 10 ADD, 11 SLT)
//  - Cin       in   1      adder carry-in; driven 1 by the controller when ALU_cont[3]|ALU_cont[2]
//  - X         out  WIDTH  registered result
//  - Cout      out  1      registered adder carry-out (MSB)
//  - Zero      out  1      registered flag, 1 when X == 0
// BEHAVIOUR
//  - One clock clk; reset rst_n is asynchronous, active-low.
//  - Reset: X=0, Cout=0, Zero=1 immediately on rst_n low; held while low, even mid-operation.
//  - Operand prep: a' = ALU_cont[3] ? ~A : A.
//  - Operand prep: b' = ALU_cont[2] ? ~B : B.
//  - Adder: {c, s} = a' + b' + Cin, WIDTH+1 bits; c is the MSB carry.
//  - Overflow: ovf = (a'[MSB]==b'[MSB]) && (s[MSB]!=a'[MSB]).
//  - op 00 -> a' & b'; op 01 -> a' | b'; op 10 -> s.
//  - op 11 -> {0.., less}, less = s[MSB] ^ ovf; signed compare stays correct on overflow.
//  - Encodings: 0000 AND, 0001 OR, 0010 ADD.
//  - Encodings: 0110 SUB (A-B), 0111 SLT (A<B), 1011 SLT reversed (B<A).
//  - Encodings: 1100 NOR, 1101 NAND; all 16 codes are legal by the rule above.
//  - Cout = c for every op, including the logic ops.
//  - Cin is used as given; the ALU never derives it from ALU_cont.
//  - Zero = ~|X_next, registered with X so both describe the same result.
//  - Latency: inputs sampled at edge N appear on X/Cout/Zero after edge N; no handshake.
//  - Fully pipelined: a new op is accepted every cycle.
// CONFIGURATION
//  - ALU_OVERFLOW_EN defined: adds output port Ovf (1 bit), registered ovf.
//    Reset value 0; valid for every op; reflects the adder regardless of op select.
//  - ALU_OVERFLOW_EN undefined: no Ovf port; overflow is used only inside SLT.
// STRUCTURE
//  - Package alu_pkg: typedef enum logic [3:0] alu_op_t (AND, OR, ADD, SUB, SLT, SLTR, NOR, NAND).
//  - alu_pkg also holds localparams for the Ainvert/Binvert bit indices and the op[1:0] codes.
//  - Sub-module alu_1bit: one bit slice with inputs a, b, ainv, binv, cin, less, op[1:0].
//    Slice outputs: res, cout, set (MSB only). Chain WIDTH slices in ripple.
//    Feed the MSB set^ovf back into slice 0 less; all other slices get less=0.
//  - Top level holds the output registers only.
// TESTING
//  - A=13, B=7, ALU_cont=0000, Cin=0 -> X=0x05; 0001 -> X=0x0F; Zero=0 in both.
//  - ADD: A=13, B=7, 0010, Cin=0 -> X=20, Cout=0.
//  - ADD: A=0x7F, B=0x01, Cin=0 -> X=0x80, Cout=0, Ovf=1 (with ALU_OVERFLOW_EN).
//  - SUB: A=13, B=7, 0110, Cin=1 -> X=6, Cout=1.
//  - SUB: A=7, B=7 -> X=0, Zero=1.
//  - SLT 0111, Cin=1: A=-3, B=7 -> X=1; A=13, B=7 -> X=0, Zero=1.
//  - SLT 0111, Cin=1: A=-128, B=1 -> X=1 (overflow-corrected).
//  - SLT reversed 1011, Cin=1: A=13, B=7 -> X=1; A=7, B=13 -> X=0.
//  - NOR 1100, Cin=1: A=0x0D, B=0x07 -> X=0xF0. NAND 1101: A=0x0D, B=0x07 -> X=0xFA.
//  - Reset: drive ops every cycle, pull rst_n low between edges.
//    Outputs go to X=0, Cout=0, Zero=1 at once, with no clock edge.
//    After release, the first result appears one edge later.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the execute-stage ALU.
//   - alu_op_t   : named 4-bit control words (ALU_cont encodings)
//   - AINV_BIT / BINV_BIT : bit positions of Ainvert / Binvert in ALU_cont
//   - OP_*       : codes carried on ALU_cont[1:0] (result select)
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int AINV_BIT = 3;
    localparam int BINV_BIT = 2;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SLT = 2'b11;

    // Named encodings; any other 4-bit code is still legal and simply follows
    // the invert/select rule.
    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_SLTR = 4'b1011,
        ALU_NOR  = 4'b1100,
        ALU_NAND = 4'b1101
    } alu_op_t;

endpackage

// File: rtl/alu_1bit.sv
// -----------------------------------------------------------------------------
// alu_1bit
// One bit slice of the ripple ALU.
//   a, b     : operand bits
//   ainv     : invert a before use
//   binv     : invert b before use
//   cin      : carry in from the next-lower slice (or the ALU carry-in)
//   less     : value selected by op 11 (only slice 0 receives a non-zero value)
//   op       : result select (AND / OR / ADD / SLT)
//   res      : selected result bit
//   cout     : full-adder carry out
//   set      : full-adder sum bit, consumed at the MSB to build the SLT value
// -----------------------------------------------------------------------------
module alu_1bit
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       ainv,
    input  logic       binv,
    input  logic       cin,
    input  logic       less,
    input  logic [1:0] op,
    output logic       res,
    output logic       cout,
    output logic       set
);

    logic a_p;
    logic b_p;
    logic sum;

    assign a_p  = ainv ? ~a : a;
    assign b_p  = binv ? ~b : b;
    assign sum  = a_p ^ b_p ^ cin;

    // The carry is kept out of the result mux so that the carry chain never
    // depends on 'less', which is itself derived from the top of the chain.
    assign cout = (a_p & b_p) | (cin & (a_p ^ b_p));
    assign set  = sum;

    always_comb begin
        // NOTE: default assigned first so every path drives res and no latch is inferred.
        res = 1'b0;
        case (op)
            OP_AND:  res = a_p & b_p;
            OP_OR:   res = a_p | b_p;
            OP_ADD:  res = sum;
            OP_SLT:  res = less;
            default: res = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_8bit.sv
// -----------------------------------------------------------------------------
// alu_8bit
// Execute-stage ALU: AND / OR / ADD / SUB / SLT and inverted-operand variants
// on two WIDTH-bit two's complement operands, built from a ripple chain of
// alu_1bit slices. Result and flags are registered (one cycle latency, a new
// operation every cycle).
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   A, B     : operands
//   ALU_cont : [3] Ainvert, [2] Binvert, [1:0] result select
//   Cin      : adder carry-in, used exactly as given
//   X        : registered result
//   Cout     : registered MSB carry of the adder (valid for every op)
//   Zero     : registered X == 0
//   Ovf      : registered signed overflow of the adder (only when the
//              ALU_OVERFLOW_EN macro is defined)
// Configuration macro: ALU_OVERFLOW_EN
// -----------------------------------------------------------------------------
module alu_8bit
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_cont,
    input  logic             Cin,
    output logic [WIDTH-1:0] X,
    output logic             Cout,
    output logic             Zero
`ifdef ALU_OVERFLOW_EN
    ,
    output logic             Ovf
`endif
);

    logic [WIDTH-1:0] x_d;
    logic             cout_d;
    logic             ovf_d;
    logic             slt_less;
    logic [WIDTH-2:0] unused_set;

    // Each slice keeps its own carry/result nets so the ripple chain and the
    // SLT feedback into slice 0 form no combinational loop at signal level.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic c_in;
        logic c_out;
        logic less;
        logic res;
        logic set;

        if (i == 0) begin : g_first
            assign c_in = Cin;
            assign less = slt_less;
        end else begin : g_rest
            assign c_in = g_bit[i-1].c_out;
            assign less = 1'b0;
        end

        alu_1bit u_slice (
            .a    (A[i]),
            .b    (B[i]),
            .ainv (ALU_cont[AINV_BIT]),
            .binv (ALU_cont[BINV_BIT]),
            .cin  (c_in),
            .less (less),
            .op   (ALU_cont[1:0]),
            .res  (res),
            .cout (c_out),
            .set  (set)
        );

        assign x_d[i] = res;

        // Only the MSB sum bit is meaningful for SLT.
        if (i < WIDTH-1) begin : g_unused_set
            assign unused_set[i] = set;
        end
    end

    assign cout_d   = g_bit[WIDTH-1].c_out;
    // Carry into and out of the MSB differ exactly when the signed sum
    // overflows (same-sign operands producing an opposite-sign sum).
    assign ovf_d    = g_bit[WIDTH-1].c_in ^ g_bit[WIDTH-1].c_out;
    // Sign of the true (infinite-precision) sum: corrects SLT on overflow.
    assign slt_less = g_bit[WIDTH-1].set ^ ovf_d;

    logic [WIDTH-1:0] x_q;
    logic             cout_q;
    logic             zero_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            x_q    <= '0;
            cout_q <= 1'b0;
            zero_q <= 1'b1;
        end else begin
            x_q    <= x_d;
            cout_q <= cout_d;
            zero_q <= ~|x_d;
        end
    end

    assign X    = x_q;
    assign Cout = cout_q;
    assign Zero = zero_q;

`ifdef ALU_OVERFLOW_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign Ovf = ovf_q;
`endif

endmodule

// File: tb/tb_alu_8bit.sv
// -----------------------------------------------------------------------------
// tb_alu_8bit
// Scoreboard bench for alu_8bit: the driver pushes the expected response for
// every operation it issues, a separate monitor pops and compares after each
// capturing edge. Expected values come from hand-derived constants and from a
// signed/unsigned integer model of the ALU rules.
// -----------------------------------------------------------------------------
module tb_alu_8bit;
    import alu_pkg::*;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   cont;
    logic         cin;
    logic [W-1:0] x;
    logic         cout;
    logic         zero;
`ifdef ALU_OVERFLOW_EN
    logic         ovf;
`endif

    logic stim_vld;

    typedef struct {
        string        name;
        logic [W-1:0] x;
        logic         cout;
        logic         zero;
        logic         ovf;
    } exp_t;

    exp_t exp_q[$];

    int checks;
    int errors;

    alu_8bit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .A        (a),
        .B        (b),
        .ALU_cont (cont),
        .Cin      (cin),
        .X        (x),
        .Cout     (cout),
        .Zero     (zero)
`ifdef ALU_OVERFLOW_EN
        ,
        .Ovf      (ovf)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: signed and unsigned integer arithmetic on the
    // prepared operands.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic [3:0] c, input logic ci);
        exp_t         e;
        logic [W-1:0] ap;
        logic [W-1:0] bp;
        int           us;
        int           ss;
        int           sa;
        int           sb;
        ap = c[3] ? ~av : av;
        bp = c[2] ? ~bv : bv;
        us = int'(ap) + int'(bp) + int'(ci);
        sa = $signed(ap);
        sb = $signed(bp);
        ss = sa + sb + int'(ci);
        case (c[1:0])
            2'd0:    e.x = ap & bp;
            2'd1:    e.x = ap | bp;
            2'd2:    e.x = us[W-1:0];
            default: e.x = (ss < 0) ? 8'd1 : 8'd0;
        endcase
        e.cout = (us >= 256);
        e.ovf  = (ss > 127) || (ss < -128);
        e.zero = (e.x == 8'd0);
        e.name = "rand";
        return e;
    endfunction

    task automatic drive_vec(input logic [W-1:0] av, input logic [W-1:0] bv,
                             input logic [3:0] c, input logic ci, input exp_t e);
        a        = av;
        b        = bv;
        cont     = c;
        cin      = ci;
        stim_vld = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic send_dir(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic [3:0] c, input logic ci, input logic [W-1:0] ex,
                            input logic ec, input logic ez, input logic eo);
        exp_t e;
        e.name = name;
        e.x    = ex;
        e.cout = ec;
        e.zero = ez;
        e.ovf  = eo;
        @(negedge clk);
        drive_vec(av, bv, c, ci, e);
    endtask

    task automatic send_rand();
        logic [W-1:0] av;
        logic [W-1:0] bv;
        logic [3:0]   c;
        logic         ci;
        av = W'($urandom);
        bv = W'($urandom);
        c  = 4'($urandom_range(0, 15));
        ci = 1'($urandom);
        @(negedge clk);
        drive_vec(av, bv, c, ci, model(av, bv, c, ci));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_x"},    32'(x),    32'h0);
        check({tag, "_cout"}, 32'(cout), 32'h0);
        check({tag, "_zero"}, 32'(zero), 32'h1);
`ifdef ALU_OVERFLOW_EN
        check({tag, "_ovf"},  32'(ovf),  32'h0);
`endif
    endtask

    // Monitor: after every edge that captured a valid operation, compare.
    always @(posedge clk) begin
        if (rst_n && stim_vld) begin
            exp_t e;
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow: got output 0x%0h expected no pending entry", x);
            end else begin
                e = exp_q.pop_front();
                check({e.name, "_x"},    32'(x),    32'(e.x));
                check({e.name, "_cout"}, 32'(cout), 32'(e.cout));
                check({e.name, "_zero"}, 32'(zero), 32'(e.zero));
`ifdef ALU_OVERFLOW_EN
                check({e.name, "_ovf"},  32'(ovf),  32'(e.ovf));
`endif
            end
        end
    end

    initial begin
        checks   = 0;
        errors   = 0;
        stim_vld = 1'b0;
        a        = '0;
        b        = '0;
        cont     = '0;
        cin      = 1'b0;
        rst_n    = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("reset_initial");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        //       name         A      B      cont     Cin   X      Cout  Zero  Ovf
        send_dir("and",       8'h0D, 8'h07, ALU_AND,  1'b0, 8'h05, 1'b0, 1'b0, 1'b0);
        send_dir("or",        8'h0D, 8'h07, ALU_OR,   1'b0, 8'h0F, 1'b0, 1'b0, 1'b0);
        send_dir("add",       8'h0D, 8'h07, ALU_ADD,  1'b0, 8'h14, 1'b0, 1'b0, 1'b0);
        send_dir("add_ovf",   8'h7F, 8'h01, ALU_ADD,  1'b0, 8'h80, 1'b0, 1'b0, 1'b1);
        send_dir("sub",       8'h0D, 8'h07, ALU_SUB,  1'b1, 8'h06, 1'b1, 1'b0, 1'b0);
        send_dir("sub_zero",  8'h07, 8'h07, ALU_SUB,  1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
        send_dir("slt_neg",   8'hFD, 8'h07, ALU_SLT,  1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
        send_dir("slt_ge",    8'h0D, 8'h07, ALU_SLT,  1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
        send_dir("slt_ovf",   8'h80, 8'h01, ALU_SLT,  1'b1, 8'h01, 1'b1, 1'b0, 1'b1);
        send_dir("sltr_lt",   8'h0D, 8'h07, ALU_SLTR, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        send_dir("sltr_ge",   8'h07, 8'h0D, ALU_SLTR, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
        send_dir("nor",       8'h0D, 8'h07, ALU_NOR,  1'b1, 8'hF0, 1'b1, 1'b0, 1'b0);
        send_dir("nand",      8'h0D, 8'h07, ALU_NAND, 1'b1, 8'hFA, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            send_rand();
        end

        // Reset asserted between edges while operations keep arriving.
        send_rand();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("reset_async");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            stim_vld = 1'b0;
            a        = W'($urandom);
            b        = W'($urandom);
            cont     = 4'($urandom_range(0, 15));
            cin      = 1'($urandom);
        end
        #1 check_reset_outputs("reset_held");

        // Release and present an operation in the same low phase: its result
        // must show up right after the next rising edge.
        @(negedge clk);
        rst_n = 1'b1;
        begin
            exp_t e;
            e      = model(8'h22, 8'h11, ALU_SUB, 1'b1);
            e.name = "post_reset";
            drive_vec(8'h22, 8'h11, ALU_SUB, 1'b1, e);
        end
        #1 check_reset_outputs("reset_release");

        for (int i = 0; i < 20; i++) begin
            send_rand();
        end
        @(negedge clk);
        stim_vld = 1'b0;

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) begin
            @(posedge clk);
        end
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending entries expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
